vx_tensor_result_drain: RTL and testbench



---
 rtl/VX_tensor_pkg.sv | 27 ++
 rtl/vx_tensor_tile_buffer.sv | 78 +++++++
 rtl/vx_tensor_result_drain.sv | 139 +++++++++++++
 tb/tb_vx_tensor_result_drain.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/VX_tensor_pkg.sv
// rtl/VX_tensor_pkg.sv - shared tensor core tile/row types for the DPU output side and result drain
`ifndef NW_WIDTH
`define NW_WIDTH 4
`endif

package VX_tensor_pkg;

  localparam int TENSOR_DIM = 4;

  typedef logic [3:0][31:0]      tensor_row_t;
  typedef logic [3:0][3:0][31:0] tensor_tile_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } drain_state_t;

  typedef struct packed {
    logic [`NW_WIDTH-1:0] wid;
    tensor_tile_t         tile;
  } tile_entry_t;

  function automatic int beat_idx_width(input int num_beats);
    return (num_beats > 1) ? $clog2(num_beats) : 1;
  endfunction

endpackage

// File: rtl/vx_tensor_tile_buffer.sv
// rtl/vx_tensor_tile_buffer.sv - FIFO of {wid, tile} with registered full/empty and bypass when empty
`ifndef NW_WIDTH
`define NW_WIDTH 4
`endif

module vx_tensor_tile_buffer
  import VX_tensor_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  tile_entry_t push_entry,
  input  logic        pop,
  output tile_entry_t head_entry,
  output logic        head_valid,
  output logic        full
);

  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);

  tile_entry_t   mem [BUF_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          empty;
  logic          bypass;
  logic          do_write;
  logic          do_read;

  // A tile pushed into an empty buffer is visible at the head in the same cycle.
  assign bypass     = empty && push && pop;
  assign do_write   = push && !bypass;
  assign do_read    = pop && !empty;
  assign head_valid = !empty || push;
  assign head_entry = empty ? push_entry : mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_write && !do_read) begin
      count_next = count + CW'(1);
    end else if (!do_write && do_read) begin
      count_next = count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      count <= count_next;
      full  <= (count_next == CW'(BUF_DEPTH));
      empty <= (count_next == '0);
      if (do_write) begin
        wr_ptr <= (wr_ptr == AW'(BUF_DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      end
      if (do_read) begin
        rd_ptr <= (rd_ptr == AW'(BUF_DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  a_no_pop_empty: assert property (@(posedge clk) disable iff (reset) !(pop && empty && !push));

endmodule

// File: rtl/vx_tensor_result_drain.sv
// rtl/vx_tensor_result_drain.sv - buffers DPU result tiles and drains them as row beats to commit
// Optional perf_tiles/perf_stall_cycles outputs under TENSOR_DRAIN_PERF_EN.
`ifndef NW_WIDTH
`define NW_WIDTH 4
`endif

module vx_tensor_result_drain
  import VX_tensor_pkg::*;
#(
  parameter int BUF_DEPTH     = 2,
  parameter int ROWS_PER_BEAT = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 valid_in,
  output logic                                 ready_in,
  input  tensor_tile_t                         D_tile,
  input  logic [`NW_WIDTH-1:0]                 D_wid,
  output logic                                 commit_valid,
  input  logic                                 commit_ready,
  output logic [`NW_WIDTH-1:0]                 commit_wid,
  output logic [1:0]                           commit_row,
  output logic [ROWS_PER_BEAT-1:0][3:0][31:0]  commit_data,
  output logic                                 commit_eop
`ifdef TENSOR_DRAIN_PERF_EN
  ,
  output logic [31:0]                          perf_tiles,
  output logic [31:0]                          perf_stall_cycles
`endif
);

  localparam int NUM_BEATS = TENSOR_DIM / ROWS_PER_BEAT;
  localparam int BW        = beat_idx_width(NUM_BEATS);

  drain_state_t         state;
  drain_state_t         state_next;
  logic [BW-1:0]        beat_idx;
  logic [`NW_WIDTH-1:0] out_wid;
  tensor_tile_t         out_tile;
  tile_entry_t          push_entry;
  tile_entry_t          head_entry;
  logic                 head_valid;
  logic                 buf_full;
  logic                 push;
  logic                 load;
  logic                 fire;
  logic                 last_beat;

  assign ready_in   = !buf_full;
  assign push       = valid_in && ready_in;
  assign push_entry = '{wid: D_wid, tile: D_tile};
  assign fire       = commit_valid && commit_ready;
  assign last_beat  = (beat_idx == BW'(NUM_BEATS - 1));

  // The output register holds the tile being drained; loading it pops the buffer.
  vx_tensor_tile_buffer #(
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buffer (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (load),
    .head_entry (head_entry),
    .head_valid (head_valid),
    .full       (buf_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (head_valid) state_next = ST_DRAIN;
      ST_DRAIN: if (fire && last_beat && !head_valid) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    commit_valid = (state == ST_DRAIN);
    load         = 1'b0;
    if (state == ST_IDLE) begin
      load = head_valid;
    end else if (state == ST_DRAIN) begin
      load = fire && last_beat && head_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_idx <= '0;
      out_wid  <= '0;
      out_tile <= '0;
    end else if (load) begin
      beat_idx <= '0;
      out_wid  <= head_entry.wid;
      out_tile <= head_entry.tile;
    end else if (fire) begin
      beat_idx <= last_beat ? '0 : beat_idx + BW'(1);
    end
  end

  assign commit_wid = out_wid;
  assign commit_eop = commit_valid && last_beat;
  assign commit_row = 2'(int'(beat_idx) * ROWS_PER_BEAT);

  always_comb begin
    commit_data = '0;
    for (int r = 0; r < ROWS_PER_BEAT; r++) begin
      commit_data[r] = out_tile[2'(int'(commit_row) + r)];
    end
  end

  a_eop_on_last: assert property (@(posedge clk) disable iff (reset) (fire && commit_eop) |-> last_beat);

`ifdef TENSOR_DRAIN_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_tiles        <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (fire && last_beat && (perf_tiles != '1)) begin
        perf_tiles <= perf_tiles + 32'd1;
      end
      if (commit_valid && !commit_ready && (perf_stall_cycles != '1)) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vx_tensor_result_drain.sv
// tb/tb_vx_tensor_result_drain.sv - scoreboard bench for vx_tensor_result_drain (ROWS_PER_BEAT 1/2/4)
`ifndef NW_WIDTH
`define NW_WIDTH 4
`endif

module tb_vx_tensor_result_drain;
  import VX_tensor_pkg::*;

  typedef struct {
    logic [`NW_WIDTH-1:0] wid;
    logic [1:0]           row;
    tensor_row_t          data;
    logic                 eop;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                      valid_in, ready_in;
  tensor_tile_t              D_tile;
  logic [`NW_WIDTH-1:0]      D_wid;
  logic                      commit_valid, commit_ready, commit_eop;
  logic [`NW_WIDTH-1:0]      commit_wid;
  logic [1:0]                commit_row;
  logic [0:0][3:0][31:0]     commit_data;

  logic                      valid2, ready2, c2_valid, c2_eop;
  logic [`NW_WIDTH-1:0]      c2_wid;
  logic [1:0]                c2_row;
  logic [1:0][3:0][31:0]     c2_data;

  logic                      valid4, ready4, c4_valid, c4_eop;
  logic [`NW_WIDTH-1:0]      c4_wid;
  logic [1:0]                c4_row;
  logic [3:0][3:0][31:0]     c4_data;

`ifdef TENSOR_DRAIN_PERF_EN
  logic [31:0] perf_tiles, perf_stall_cycles;
  logic [31:0] p2_tiles, p2_stall, p4_tiles, p4_stall;
`endif

  vx_tensor_result_drain #(.BUF_DEPTH(2), .ROWS_PER_BEAT(1)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
    .D_tile(D_tile), .D_wid(D_wid), .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_wid(commit_wid), .commit_row(commit_row), .commit_data(commit_data), .commit_eop(commit_eop)
`ifdef TENSOR_DRAIN_PERF_EN
    , .perf_tiles(perf_tiles), .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  vx_tensor_result_drain #(.BUF_DEPTH(2), .ROWS_PER_BEAT(2)) dut2 (
    .clk(clk), .reset(reset), .valid_in(valid2), .ready_in(ready2),
    .D_tile(D_tile), .D_wid(D_wid), .commit_valid(c2_valid), .commit_ready(commit_ready),
    .commit_wid(c2_wid), .commit_row(c2_row), .commit_data(c2_data), .commit_eop(c2_eop)
`ifdef TENSOR_DRAIN_PERF_EN
    , .perf_tiles(p2_tiles), .perf_stall_cycles(p2_stall)
`endif
  );

  vx_tensor_result_drain #(.BUF_DEPTH(2), .ROWS_PER_BEAT(4)) dut4 (
    .clk(clk), .reset(reset), .valid_in(valid4), .ready_in(ready4),
    .D_tile(D_tile), .D_wid(D_wid), .commit_valid(c4_valid), .commit_ready(commit_ready),
    .commit_wid(c4_wid), .commit_row(c4_row), .commit_data(c4_data), .commit_eop(c4_eop)
`ifdef TENSOR_DRAIN_PERF_EN
    , .perf_tiles(p4_tiles), .perf_stall_cycles(p4_stall)
`endif
  );

  int    vectors     = 0;
  int    miscompares = 0;
  beat_t sb[$];
  beat_t mon_e;
  int    cyc = 0;
  int    fire_cnt = 0;
  int    mark = 0;
  int    first_fire = 0;
  int    last_fire = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic tensor_tile_t rand_tile();
    tensor_tile_t t;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r][c] = $urandom;
    return t;
  endfunction

  always @(posedge clk) cyc++;

  // Scoreboard monitor for the ROWS_PER_BEAT=1 instance.
  always @(negedge clk) begin
    if (!reset && commit_valid && commit_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", 512'(commit_valid), 512'(1'b0));
      end else begin
        mon_e = sb.pop_front();
        check("beat_wid", 512'(commit_wid), 512'(mon_e.wid));
        check("beat_row", 512'(commit_row), 512'(mon_e.row));
        check("beat_data", 512'(commit_data), 512'(mon_e.data));
        check("beat_eop", 512'(commit_eop), 512'(mon_e.eop));
      end
      if (fire_cnt == mark) first_fire = cyc;
      last_fire = cyc;
      fire_cnt++;
    end
  end

  task automatic push_tile(input tensor_tile_t t, input logic [`NW_WIDTH-1:0] w);
    int n = 0;
    valid_in = 1'b1;
    D_tile   = t;
    D_wid    = w;
    @(negedge clk);
    while (!ready_in && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", 512'(ready_in), 512'(1'b1));
    @(posedge clk);
    for (int b = 0; b < 4; b++) begin
      beat_t e;
      e.wid  = w;
      e.row  = 2'(b);
      e.data = t[b];
      e.eop  = (b == 3);
      sb.push_back(e);
    end
    #1 valid_in = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 512'(sb.size()), 512'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tensor_tile_t t, ta, tb, tc;
    logic [`NW_WIDTH-1:0] wa;

    reset = 1'b1; valid_in = 1'b0; valid2 = 1'b0; valid4 = 1'b0;
    commit_ready = 1'b1; D_tile = '0; D_wid = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    check("rst_ready_in", 512'(ready_in), 512'(1'b1));
    check("rst_commit_valid", 512'(commit_valid), 512'(1'b0));
    check("rst_commit_eop", 512'(commit_eop), 512'(1'b0));
    check("rst_commit_row", 512'(commit_row), 512'(0));
    check("rst_commit_wid", 512'(commit_wid), 512'(0));
    check("rst_commit_data", 512'(commit_data), 512'(0));
    check("rst_ready2", 512'(ready2), 512'(1'b1));
    check("rst_c4_valid", 512'(c4_valid), 512'(1'b0));

    // single tile, D[r][c] = r*4+c, wid 3
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r][c] = 32'(r * 4 + c);
    push_tile(t, `NW_WIDTH'(3));
    check("t1_latency_valid", 512'(commit_valid), 512'(1'b1));
    check("t1_first_row", 512'(commit_row), 512'(0));
    wait_drain();
    @(posedge clk); #1;
    check("t1_idle_after", 512'(commit_valid), 512'(1'b0));

    // back-to-back tiles, no bubble
    mark = fire_cnt;
    push_tile(rand_tile(), `NW_WIDTH'(1));
    push_tile(rand_tile(), `NW_WIDTH'(2));
    wait_drain();
    check("t2_beat_count", 512'(fire_cnt - mark), 512'(8));
    check("t2_no_bubble", 512'(last_fire - first_fire), 512'(7));
    repeat (2) @(posedge clk); #1;

    // stall mid-tile, buffer fills, order preserved
    ta = rand_tile(); tb = rand_tile(); tc = rand_tile();
    wa = `NW_WIDTH'(5);
    push_tile(ta, wa);
    @(posedge clk); @(posedge clk); #1 commit_ready = 1'b0;
    push_tile(tb, `NW_WIDTH'(6));
    push_tile(tc, `NW_WIDTH'(7));
    @(negedge clk);
    check("t3_ready_drop", 512'(ready_in), 512'(1'b0));
    for (int i = 0; i < 8; i++) begin
      check("t3_frozen", 512'({commit_valid, commit_eop, commit_row, commit_wid, commit_data}),
            512'({1'b1, 1'b0, 2'd2, wa, ta[2]}));
      @(negedge clk);
    end
    @(posedge clk); #1 commit_ready = 1'b1;
    wait_drain();
    repeat (2) @(posedge clk); #1;
    check("t3_ready_back", 512'(ready_in), 512'(1'b1));

    // ROWS_PER_BEAT = 2
    t = rand_tile(); D_tile = t; D_wid = `NW_WIDTH'(4); valid2 = 1'b1;
    @(negedge clk);
    check("rpb2_ready", 512'(ready2), 512'(1'b1));
    @(posedge clk); #1 valid2 = 1'b0;
    check("rpb2_beat0", 512'({c2_valid, c2_eop, c2_row, c2_wid, c2_data}),
          512'({1'b1, 1'b0, 2'd0, `NW_WIDTH'(4), t[1], t[0]}));
    @(posedge clk); #1;
    check("rpb2_beat1", 512'({c2_valid, c2_eop, c2_row, c2_wid, c2_data}),
          512'({1'b1, 1'b1, 2'd2, `NW_WIDTH'(4), t[3], t[2]}));
    @(posedge clk); #1;
    check("rpb2_done", 512'(c2_valid), 512'(1'b0));

    // ROWS_PER_BEAT = 4
    t = rand_tile(); D_tile = t; D_wid = `NW_WIDTH'(8); valid4 = 1'b1;
    @(negedge clk);
    check("rpb4_ready", 512'(ready4), 512'(1'b1));
    @(posedge clk); #1 valid4 = 1'b0;
    check("rpb4_beat0", 512'({c4_valid, c4_eop, c4_row, c4_wid}), 512'({1'b1, 1'b1, 2'd0, `NW_WIDTH'(8)}));
    check("rpb4_data", 512'(c4_data), 512'(t));
    @(posedge clk); #1;
    check("rpb4_done", 512'(c4_valid), 512'(1'b0));

    // reset during beat 2 with one tile buffered
    push_tile(rand_tile(), `NW_WIDTH'(9));
    push_tile(rand_tile(), `NW_WIDTH'(10));
    @(posedge clk); #1;
    check("t5_at_beat2", 512'(commit_row), 512'(2));
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    sb.delete();
    check("t5_valid_cleared", 512'(commit_valid), 512'(1'b0));
    check("t5_ready_in", 512'(ready_in), 512'(1'b1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t5_no_beats", 512'(commit_valid), 512'(1'b0));
    end

`ifdef TENSOR_DRAIN_PERF_EN
    check("perf_rst_tiles", 512'(perf_tiles), 512'(0));
    check("perf_rst_stall", 512'(perf_stall_cycles), 512'(0));
    @(posedge clk); #1 commit_ready = 1'b0;
    push_tile(rand_tile(), `NW_WIDTH'(11));
    push_tile(rand_tile(), `NW_WIDTH'(12));
    push_tile(rand_tile(), `NW_WIDTH'(13));
    repeat (3) @(posedge clk);
    #1 commit_ready = 1'b1;
    wait_drain();
    repeat (2) @(posedge clk); #1;
    check("perf_tiles", 512'(perf_tiles), 512'(3));
    check("perf_stall_cycles", 512'(perf_stall_cycles), 512'(5));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
